// File: rtl/control_unit_pipe.sv
// -----------------------------------------------------------------------------
// control_unit_pipe
//   Decode-stage control unit for an RV32I pipeline. It decodes InstrD into
//   control signals, registers them into the E stage, and, when built with
//   multiply support, keeps a multiply op in E for MUL_CYCLES cycles.
//
//   Build option: define RV32M_MUL_EN to decode R-type funct7=0000001 /
//   funct3=000 as MUL and to build the E-stage occupancy FSM. Without it
//   those encodings are illegal, and StallD simply follows StallE.
//
// Ports
//   clk, rst      clock and asynchronous active-low reset
//   InstrD        decode-stage instruction
//   ValidD        InstrD is valid (0 loads a bubble)
//   StallE        hold the E-stage registers
//   FlushE        clear the E-stage registers to a bubble (wins over StallE)
//   ImmSrcD       combinational immediate select (I/S/B/J/U)
//   *E            registered E-stage controls
//   StallD        upstream hold request (multi-cycle op in E, or StallE)
// -----------------------------------------------------------------------------
module control_unit_pipe #(
  parameter int ALU_CTRL_W = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  ALUSrcE,
  output logic                  ValidE,
  output logic                  IllegalE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  StallD
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       valid;
    logic       illegal;
    logic [1:0] result_src;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t      dec;
  ctrl_t      e_q;
  logic       hold_e;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       unused_instr;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign alt    = InstrD[30];
  // Register fields are handled by the datapath, not by this block.
  assign unused_instr = ^{InstrD[24:15], InstrD[11:7]};

  // Shared funct3 table for R-type and I-ALU; only R-type may select SUB.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                  input logic       alt_op,
                                                  input logic       allow_sub);
    case (f3)
      3'b000:  return (allow_sub && alt_op) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt_op ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (opcode)
      OP_SW:   ImmSrcD = IMM_S;
      OP_BR:   ImmSrcD = IMM_B;
      OP_JAL:  ImmSrcD = IMM_J;
      OP_LUI:  ImmSrcD = IMM_U;
      default: ImmSrcD = IMM_I;
    endcase
  end

`ifdef RV32M_MUL_EN
  logic is_mul;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    dec       = '0;
    dec.valid = 1'b1;
`ifdef RV32M_MUL_EN
    is_mul    = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_MUL_EN
          if (funct3 == 3'b000) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALU_MUL;
            is_mul        = ValidD;
          end else begin
            dec.illegal = 1'b1;
          end
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_from_funct3(funct3, alt, 1'b1);
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_from_funct3(funct3, alt, 1'b0);
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_PASSB;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (!ValidD) dec = '0;
  end

`ifdef RV32M_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_hold;
  logic       load_e;

  assign busy_hold = (state_q == BUSY) && (cnt_q != 4'd0);
  assign StallD    = busy_hold || StallE;
  assign hold_e    = StallD;
  assign load_e    = !FlushE && !hold_e;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FlushE) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (load_e && is_mul) begin
      // Also covers a MUL arriving on the release cycle of a previous MUL.
      state_d = BUSY;
      cnt_d   = 4'(MUL_CYCLES - 1);
    end else if (state_q == BUSY) begin
      if (cnt_q == 4'd0)  state_d = IDLE;
      else if (!StallE)   cnt_d   = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  localparam int unused_mul_cycles = MUL_CYCLES;

  assign StallD = StallE;
  assign hold_e = StallE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst)         e_q <= '0;
    else if (FlushE)  e_q <= '0;
    else if (!hold_e) e_q <= dec;
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ALUSrcE     = e_q.alu_src;
  assign ValidE      = e_q.valid;
  assign IllegalE    = e_q.illegal;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = ALU_CTRL_W'(e_q.alu_op);

endmodule

// File: tb/tb_control_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_control_unit_pipe
//   Directed scenarios with literal expectations, then randomized traffic
//   (instructions, ValidD, StallE, FlushE, reset pulses) compared every cycle
//   against an instruction-level reference model. Honors RV32M_MUL_EN.
// -----------------------------------------------------------------------------
module tb_control_unit_pipe;

  localparam int ALU_CTRL_W = 4;
  localparam int MUL_CYCLES = 4;
`ifdef RV32M_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [31:0] I_SUB = 32'h40B50533;
  localparam logic [31:0] I_LW  = 32'h0000A283;
  localparam logic [31:0] I_SW  = 32'h00512023;
  localparam logic [31:0] I_MUL = 32'h02B50533;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  localparam logic [6:0] OPS [7] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                     7'b0100011, 7'b1100011, 7'b1101111,
                                     7'b0110111};
  // ALU code chosen by funct3 when no alternate encoding applies.
  localparam int F3_OP [8] = '{0, 6, 5, 9, 4, 7, 3, 2};

  typedef struct packed {
    logic                  regw;
    logic                  memw;
    logic                  br;
    logic                  jmp;
    logic                  alusrc;
    logic                  valid;
    logic                  illegal;
    logic [1:0]            res;
    logic [ALU_CTRL_W-1:0] alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;

  logic [2:0]            ImmSrcD;
  logic                  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic                  ValidE, IllegalE, StallD;
  logic [1:0]            ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;

  exp_t act_ctl;
  exp_t exp_ctl = '0;
  int   occ = 0;          // remaining E-stage cycles of an in-flight multiply
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  control_unit_pipe #(.ALU_CTRL_W(ALU_CTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .InstrD(instr_d), .ValidD(valid_d),
    .StallE(stall_e), .FlushE(flush_e), .ImmSrcD(ImmSrcD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ValidE(ValidE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .StallD(StallD)
  );

  always #5 clk = ~clk;

  assign act_ctl = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ValidE,
                    IllegalE, ResultSrcE, ALUControlE};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic v);
    exp_t e;
    int   f3;
    bit   alt;
    int   code;
    e = '0;
    if (!v) return e;
    e.valid = 1'b1;
    f3  = int'(ins[14:12]);
    alt = ins[30];
    case (ins[6:0])
      7'b0110011: begin
        if (ins[31:25] == 7'b0000001) begin
          if (MUL_EN && f3 == 0) begin
            e.regw = 1'b1;
            e.alu  = ALU_CTRL_W'(10);
          end else begin
            e.illegal = 1'b1;
          end
        end else begin
          code = F3_OP[f3];
          if (alt && f3 == 0) code = 1;
          if (alt && f3 == 5) code = 8;
          e.regw = 1'b1;
          e.alu  = ALU_CTRL_W'(code);
        end
      end
      7'b0010011: begin
        code = F3_OP[f3];
        if (alt && f3 == 5) code = 8;
        e.regw   = 1'b1;
        e.alusrc = 1'b1;
        e.alu    = ALU_CTRL_W'(code);
      end
      7'b0000011: begin e.regw = 1'b1; e.alusrc = 1'b1; e.res = 2'd1; end
      7'b0100011: begin e.memw = 1'b1; e.alusrc = 1'b1; end
      7'b1100011: begin e.br = 1'b1; e.alu = ALU_CTRL_W'(1); end
      7'b1101111: begin e.jmp = 1'b1; e.regw = 1'b1; e.res = 2'd2; end
      7'b0110111: begin e.regw = 1'b1; e.alusrc = 1'b1; e.alu = ALU_CTRL_W'(11); end
      default:    e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic bit ref_is_mul(input logic [31:0] ins, input logic v);
    return MUL_EN && v && ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001
           && ins[14:12] == 3'b000;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs the DUT just saw.
  task automatic model_edge();
    if (!rst || flush_e) begin
      exp_ctl = '0;
      occ     = 0;
    end else if (stall_e || occ > 1) begin
      if (!stall_e)      occ--;
      else if (occ == 1) occ = 0;
    end else begin
      exp_ctl = ref_decode(instr_d, valid_d);
      occ     = ref_is_mul(instr_d, valid_d) ? MUL_CYCLES : 0;
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("e_ctl", 64'(act_ctl), 64'(exp_ctl));
      check("stall_d", 64'(StallD), 64'(stall_e || (occ > 1)));
      check("imm_src", 64'(ImmSrcD), 64'(ref_imm(instr_d)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl);
    instr_d = ins;
    valid_d = v;
    stall_e = st;
    flush_e = fl;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic do_reset(input int cycles);
    valid_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    rst     = 1'b0;
    exp_ctl = '0;
    occ     = 0;
    #1;
    check("rst_ctl", 64'(act_ctl), 64'd0);
    check("rst_stall_d", 64'(StallD), 64'd0);
    repeat (cycles) step(instr_d, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = int'($urandom_range(0, 7));
    if (k < 7) ins[6:0] = OPS[k];
    case ($urandom_range(0, 3))
      0:       ins[31:25] = 7'h00;
      1:       ins[31:25] = 7'h20;
      2:       ins[31:25] = 7'h01;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk_en = 1'b1;
    do_reset(2);

    // sub
    step(I_SUB, 1'b1, 1'b0, 1'b0);
    check("sub_alu", 64'(ALUControlE), 64'd1);
    check("sub_regw", 64'(RegWriteE), 64'd1);
    check("sub_alusrc", 64'(ALUSrcE), 64'd0);
    check("sub_valid", 64'(ValidE), 64'd1);

    // lw then sw
    step(I_LW, 1'b1, 1'b0, 1'b0);
    check("lw_res", 64'(ResultSrcE), 64'd1);
    check("lw_regw", 64'(RegWriteE), 64'd1);
    instr_d = I_SW;
    #1;
    check("sw_imm", 64'(ImmSrcD), 64'd1);
    step(I_SW, 1'b1, 1'b0, 1'b0);
    check("sw_memw", 64'(MemWriteE), 64'd1);
    check("sw_regw", 64'(RegWriteE), 64'd0);

`ifdef RV32M_MUL_EN
    // multiply occupies E for MUL_CYCLES cycles
    step(I_MUL, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MUL_CYCLES; i++) begin
      check("mul_alu", 64'(ALUControlE), 64'd10);
      check("mul_stall_d", 64'(StallD), 64'(i < MUL_CYCLES - 1));
      if (i < MUL_CYCLES - 1) step(32'h0, 1'b0, 1'b0, 1'b0);
    end
    step(32'h0, 1'b0, 1'b0, 1'b0);
    check("mul_release", 64'(ValidE), 64'd0);

    // flush in the second busy cycle
    step(I_MUL, 1'b1, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    check("busy2_stall_d", 64'(StallD), 64'd1);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    check("flush_valid", 64'(ValidE), 64'd0);
    check("flush_stall_d", 64'(StallD), 64'd0);
    step(I_SUB, 1'b1, 1'b0, 1'b0);
    check("after_flush_load", 64'(ALUControlE), 64'd1);
`else
    step(I_MUL, 1'b1, 1'b0, 1'b0);
    check("mul_illegal", 64'(IllegalE), 64'd1);
    check("mul_regw", 64'(RegWriteE), 64'd0);
    check("mul_stall_d", 64'(StallD), 64'd0);
`endif

    // illegal opcode, then stall+flush together
    step(I_BAD, 1'b1, 1'b0, 1'b0);
    check("bad_illegal", 64'(IllegalE), 64'd1);
    check("bad_wen", 64'({RegWriteE, MemWriteE, BranchE, JumpE}), 64'd0);
    step(I_SUB, 1'b1, 1'b1, 1'b1);
    check("flush_wins", 64'(act_ctl), 64'd0);

    // reset pulse mid-stream, first edge after release loads
    step(I_LW, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    step(I_SUB, 1'b1, 1'b0, 1'b0);
    check("post_rst_load", 64'(ALUControlE), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(2);
      step(rand_instr(), $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
